spi_slave_core: RTL and testbench

Parametrised SPI slave running in the system clock domain. It oversamples `sclk`, `cs` and `mosi` through synchronisers and supports all four SPI modes, selectable per frame. It receives and transmits full-duplex words of `DATA_W` bits, with a one-entry TX holding buffer behind a valid/ready handshake. It sits between the SPI pins and the register/FIFO logic; `rx_valid` pulses once per completed word.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_pin_sync.sv | 37 +++
 rtl/spi_slave_core.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave: FSM states, the latched
// {CPOL, CPHA} mode word, and the sample-edge decision.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        WAIT_CS_HIGH
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // rise=1 for a rising sclk edge, 0 for a falling one. The leading edge is
    // the rise when CPOL=0, and CPHA=1 moves sampling to the trailing edge.
    function automatic logic is_sample_edge(spi_mode_t m, logic rise);
        return rise ^ m.cpol ^ m.cpha;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall strobes
// derived from the synchronised level.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   prev_q, prev_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], pin};
        prev_d  = chain_q[SYNC_STAGES-1];
    end

    // Chain resets low so a cs held low across reset produces no false fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign level = chain_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// Oversampled SPI slave, all four modes, full-duplex DATA_W-bit words with a
// one-entry TX holding register behind a valid/ready handshake.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    input  logic [1:0]        mode,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_abort
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] i);
        return (LSB_FIRST != 0) ? i : LAST_BIT - i;
    endfunction

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (sclk),
        .level (sclk_lvl_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (cs),
        .level (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    spi_state_t        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  tx_idx_q, tx_idx_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              frame_abort_q, frame_abort_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;

    logic              sclk_edge, sample_evt, shift_evt, tx_load;
    logic [DATA_W-1:0] rx_word;

    assign sclk_edge  = sclk_rise | sclk_fall;
    assign sample_evt = sclk_edge & is_sample_edge(mode_q, sclk_rise);
    assign shift_evt  = sclk_edge & ~is_sample_edge(mode_q, sclk_rise);

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        bit_cnt_d     = bit_cnt_q;
        tx_idx_d      = tx_idx_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        miso_oe_d     = miso_oe_q;
        tx_load       = 1'b0;
        rx_word       = rx_shift_q;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    mode_d    = spi_mode_t'(mode);
                    bit_cnt_d = '0;
                    tx_idx_d  = '0;
                    tx_load   = 1'b1;
                    miso_oe_d = 1'b1;
                end else if (!cs_s) begin
                    // cs already low without a seen fall: refuse to join mid-frame
                    state_d = WAIT_CS_HIGH;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d       = IDLE;
                    miso_oe_d     = 1'b0;
                    frame_abort_d = (bit_cnt_q != '0);
                    bit_cnt_d     = '0;
                end else if (sample_evt) begin
                    rx_word[bit_pos(bit_cnt_q)] = mosi_s;
                    rx_shift_d = rx_word;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        tx_load    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_evt) begin
                    tx_idx_d = bit_cnt_q;
                end
            end
            WAIT_CS_HIGH: begin
                if (cs_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Load sees the pre-accept holding contents; a same-cycle accept is kept.
        if (tx_load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d    = '0;
                tx_underrun_d = 1'b1;
            end
        end
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        miso_d = (state_d == ACTIVE) ? tx_shift_d[bit_pos(tx_idx_d)] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q   <= '0;
            state_q       <= IDLE;
            mode_q        <= '0;
            bit_cnt_q     <= '0;
            tx_idx_q      <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
        end else begin
            mosi_sync_q   <= mosi_sync_d;
            state_q       <= state_d;
            mode_q        <= mode_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_idx_q      <= tx_idx_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: an LSB-first and an MSB-first instance
// share the SPI pins and the TX handshake; a simple master model drives both.
`timescale 1ns/1ps
module tb_spi_slave_core;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk, cs, mosi;
    logic [1:0]  mode;
    logic [15:0] tx_data;
    logic        tx_valid;

    logic        miso0, miso_oe0, tx_ready0, rx_valid0, tx_underrun0, frame_abort0;
    logic [15:0] rx_data0;
    logic        miso1, miso_oe1, tx_ready1, rx_valid1, tx_underrun1, frame_abort1;
    logic [15:0] rx_data1;

    always #5 clk = ~clk;

    spi_slave_core #(.DATA_W(16), .SYNC_STAGES(2), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .mode(mode),
        .miso(miso0), .miso_oe(miso_oe0), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .tx_underrun(tx_underrun0), .frame_abort(frame_abort0)
    );

    spi_slave_core #(.DATA_W(16), .SYNC_STAGES(2), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .mode(mode),
        .miso(miso1), .miso_oe(miso_oe1), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .tx_underrun(tx_underrun1), .frame_abort(frame_abort1)
    );

    int rxv0 = 0, rxv1 = 0, ur0 = 0, ur1 = 0, ab0 = 0, ab1 = 0;
    always @(negedge clk) begin
        if (rx_valid0)    rxv0 <= rxv0 + 1;
        if (rx_valid1)    rxv1 <= rxv1 + 1;
        if (tx_underrun0) ur0  <= ur0 + 1;
        if (tx_underrun1) ur1  <= ur1 + 1;
        if (frame_abort0) ab0  <= ab0 + 1;
        if (frame_abort1) ab1  <= ab1 + 1;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [1:0] cur_mode;

    task automatic frame_begin(input logic [1:0] m);
        cur_mode = m;
        mode     = m;
        sclk     = m[1];
        wait_clk(HALF);
        cs = 1'b0;
        wait_clk(2 * HALF);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(4 * HALF);
        mode = cur_mode;
    endtask

    // Master sends mo LSB first; c0/c1 collect miso of each instance in arrival order.
    task automatic xfer(input int nbits, input logic [15:0] mo,
                        output logic [15:0] c0, output logic [15:0] c1);
        c0 = '0;
        c1 = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cur_mode[0]) begin
                mosi = mo[i];
                wait_clk(HALF);
                c0[i] = miso0;
                c1[i] = miso1;
                sclk  = ~cur_mode[1];
                wait_clk(HALF);
                sclk  = cur_mode[1];
            end else begin
                sclk = ~cur_mode[1];
                mosi = mo[i];
                wait_clk(HALF);
                c0[i] = miso0;
                c1[i] = miso1;
                sclk  = cur_mode[1];
                wait_clk(HALF);
            end
            if (i == 0) mode = ~cur_mode;
        end
    endtask

    task automatic preload(input logic [15:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] tx;
        logic [15:0] mo;
        logic [15:0] exp_rx0;
        logic [15:0] exp_rx1;
        logic [15:0] exp_cap0;
        logic [15:0] exp_cap1;
    } vec_t;

    vec_t        vecs[5];
    logic [15:0] cap0, cap1;
    int          s_rxv0, s_rxv1, s_ur0, s_ur1, s_ab0, s_ab1;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // MSB-first instance sees the same serial stream, so its words are bit-reversed.
        vecs[0] = '{2'd0, 16'hA5C3, 16'h1234, 16'h1234, 16'h2C48, 16'hA5C3, 16'hC3A5};
        vecs[1] = '{2'd1, 16'hA5C3, 16'h1234, 16'h1234, 16'h2C48, 16'hA5C3, 16'hC3A5};
        vecs[2] = '{2'd2, 16'hA5C3, 16'h1234, 16'h1234, 16'h2C48, 16'hA5C3, 16'hC3A5};
        vecs[3] = '{2'd3, 16'hA5C3, 16'h1234, 16'h1234, 16'h2C48, 16'hA5C3, 16'hC3A5};
        vecs[4] = '{2'd0, 16'h00FF, 16'h0001, 16'h0001, 16'h8000, 16'h00FF, 16'hFF00};

        rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = 2'd0;
        tx_data = '0; tx_valid = 1'b0; cur_mode = 2'd0;
        wait_clk(3);
        chk("reset miso", {31'd0, miso0}, 32'd0);
        chk("reset miso_oe", {31'd0, miso_oe0}, 32'd0);
        chk("reset rx_data", {16'd0, rx_data0}, 32'd0);
        chk("reset rx_valid", {31'd0, rx_valid0}, 32'd0);
        chk("reset tx_ready", {31'd0, tx_ready0}, 32'd1);
        chk("reset tx_ready msb", {31'd0, tx_ready1}, 32'd1);
        chk("reset tx_underrun", {31'd0, tx_underrun0}, 32'd0);
        chk("reset frame_abort", {31'd0, frame_abort0}, 32'd0);
        rst_n = 1'b1;
        wait_clk(10);

        for (int v = 0; v < 5; v++) begin
            preload(vecs[v].tx);
            chk($sformatf("v%0d tx_ready after accept", v), {31'd0, tx_ready0}, 32'd0);
            s_rxv0 = rxv0; s_rxv1 = rxv1;
            frame_begin(vecs[v].mode);
            chk($sformatf("v%0d miso_oe in frame", v), {30'd0, miso_oe1, miso_oe0}, 32'd3);
            chk($sformatf("v%0d tx_ready after load", v), {31'd0, tx_ready0}, 32'd1);
            xfer(16, vecs[v].mo, cap0, cap1);
            frame_end();
            chk($sformatf("v%0d rx_data lsb", v), {16'd0, rx_data0}, {16'd0, vecs[v].exp_rx0});
            chk($sformatf("v%0d rx_data msb", v), {16'd0, rx_data1}, {16'd0, vecs[v].exp_rx1});
            chk($sformatf("v%0d miso word lsb", v), {16'd0, cap0}, {16'd0, vecs[v].exp_cap0});
            chk($sformatf("v%0d miso word msb", v), {16'd0, cap1}, {16'd0, vecs[v].exp_cap1});
            chk($sformatf("v%0d rx_valid pulses lsb", v), rxv0 - s_rxv0, 32'd1);
            chk($sformatf("v%0d rx_valid pulses msb", v), rxv1 - s_rxv1, 32'd1);
            chk($sformatf("v%0d miso_oe after frame", v), {31'd0, miso_oe0}, 32'd0);
        end

        // Two back-to-back words with a single preloaded word.
        preload(16'hA5C3);
        s_rxv0 = rxv0; s_ur0 = ur0; s_ur1 = ur1;
        frame_begin(2'd0);
        xfer(16, 16'h1234, cap0, cap1);
        chk("b2b word1 miso", {16'd0, cap0}, 32'h0000A5C3);
        chk("b2b word1 rx_data", {16'd0, rx_data0}, 32'h00001234);
        chk("b2b underrun after word1", ur0 - s_ur0, 32'd1);
        chk("b2b underrun after word1 msb", ur1 - s_ur1, 32'd1);
        xfer(16, 16'hBEEF, cap0, cap1);
        frame_end();
        chk("b2b word2 miso", {16'd0, cap0}, 32'h00000000);
        chk("b2b rx_valid pulses", rxv0 - s_rxv0, 32'd2);
        chk("b2b word2 rx_data", {16'd0, rx_data0}, 32'h0000BEEF);

        // Abort after 7 bits.
        s_rxv0 = rxv0; s_ab0 = ab0; s_ab1 = ab1;
        frame_begin(2'd0);
        xfer(7, 16'h007F, cap0, cap1);
        frame_end();
        chk("abort pulse", ab0 - s_ab0, 32'd1);
        chk("abort pulse msb", ab1 - s_ab1, 32'd1);
        chk("abort no rx_valid", rxv0 - s_rxv0, 32'd0);
        chk("abort rx_data held", {16'd0, rx_data0}, 32'h0000BEEF);
        chk("abort miso_oe", {31'd0, miso_oe0}, 32'd0);

        // Reset mid-frame, released with cs still low.
        frame_begin(2'd0);
        xfer(5, 16'h001F, cap0, cap1);
        rst_n = 1'b0;
        wait_clk(2);
        chk("midrst miso", {31'd0, miso0}, 32'd0);
        chk("midrst miso_oe", {31'd0, miso_oe0}, 32'd0);
        chk("midrst rx_data", {16'd0, rx_data0}, 32'd0);
        chk("midrst rx_valid", {31'd0, rx_valid0}, 32'd0);
        chk("midrst tx_ready", {31'd0, tx_ready0}, 32'd1);
        chk("midrst tx_underrun", {31'd0, tx_underrun0}, 32'd0);
        chk("midrst frame_abort", {31'd0, frame_abort0}, 32'd0);
        rst_n = 1'b1;
        wait_clk(2);
        s_rxv0 = rxv0;
        xfer(16, 16'h5A5A, cap0, cap1);
        chk("nojoin rx_valid", rxv0 - s_rxv0, 32'd0);
        chk("nojoin miso_oe", {31'd0, miso_oe0}, 32'd0);
        chk("nojoin rx_data", {16'd0, rx_data0}, 32'd0);
        frame_end();
        preload(16'h1357);
        frame_begin(2'd0);
        xfer(16, 16'hC0DE, cap0, cap1);
        frame_end();
        chk("rejoin rx_data", {16'd0, rx_data0}, 32'h0000C0DE);
        chk("rejoin miso word", {16'd0, cap0}, 32'h00001357);
        chk("rejoin rx_valid", rxv0 - s_rxv0, 32'd1);

        // Accept lands in the same cycle as the frame-start load.
        cur_mode = 2'd0; mode = 2'd0; sclk = 1'b0;
        wait_clk(HALF);
        s_ur0 = ur0;
        cs = 1'b0;
        wait_clk(2);
        tx_data  = 16'h6E6E;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        wait_clk(2 * HALF);
        chk("simul underrun", ur0 - s_ur0, 32'd1);
        chk("simul word retained", {31'd0, tx_ready0}, 32'd0);
        xfer(16, 16'h1111, cap0, cap1);
        chk("simul word1 miso", {16'd0, cap0}, 32'h00000000);
        chk("simul holding drained", {31'd0, tx_ready0}, 32'd1);
        xfer(16, 16'h2222, cap0, cap1);
        frame_end();
        chk("simul word2 miso lsb", {16'd0, cap0}, 32'h00006E6E);
        chk("simul word2 miso msb", {16'd0, cap1}, 32'h00007676);
        chk("simul rx_data", {16'd0, rx_data0}, 32'h00002222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
